// File: rtl/frame_ctrl.sv
// Frame sequencer: erase -> draw -> wait for frame tick -> update, with a free-running
// frame counter, a sticky pending tick and a same-cycle pixel mux to the VGA adapter.
module frame_ctrl #(
    parameter int unsigned FRAME_CYCLES = 833333,
    parameter int unsigned CNT_W        = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       erase_done,
    input  logic [7:0] erase_x,
    input  logic [6:0] erase_y,
    input  logic [2:0] erase_c,
    input  logic       draw_done,
    input  logic [7:0] draw_x,
    input  logic [6:0] draw_y,
    input  logic [2:0] draw_c,
    output logic       enable_erase,
    output logic       in_erase_state,
    output logic       enable_draw,
    output logic       update,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] c_out,
    output logic       plot,
    output logic       frame_overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_DRAW,
        ST_WAIT,
        ST_UPDATE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             tick;
    logic             tick_pending_q;

    assign tick = (cnt_q == CNT_LAST);

    // Free-running frame counter, independent of the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Sticky pending tick; a new tick wins over the UPDATE clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_pending_q <= 1'b0;
        end else if (tick) begin
            tick_pending_q <= 1'b1;
        end else if (state_q == ST_UPDATE) begin
            tick_pending_q <= 1'b0;
        end
    end

    assign frame_overrun = tick & tick_pending_q & (state_q != ST_UPDATE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, Moore control decode and pass-through pixel mux.
    always_comb begin
        state_d        = state_q;
        enable_erase   = 1'b0;
        in_erase_state = 1'b0;
        enable_draw    = 1'b0;
        update         = 1'b0;
        x_out          = '0;
        y_out          = '0;
        c_out          = '0;
        plot           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ERASE;
            end
            ST_ERASE: begin
                enable_erase   = 1'b1;
                in_erase_state = 1'b1;
                x_out          = erase_x;
                y_out          = erase_y;
                c_out          = erase_c;
                plot           = ~erase_done;
                if (erase_done) state_d = ST_DRAW;
            end
            ST_DRAW: begin
                enable_draw = 1'b1;
                x_out       = draw_x;
                y_out       = draw_y;
                c_out       = draw_c;
                plot        = ~draw_done;
                if (draw_done) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tick_pending_q) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                update  = 1'b1;
                state_d = start ? ST_ERASE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
